// File: rtl/ibex_xif_pkg.sv
// Shared CSR-channel types and the CSR read-modify-write helper.
package ibex_xif_pkg;

    localparam int unsigned CSR_ADDR_W = 12;
    localparam int unsigned CSR_DATA_W = 32;

    // CSR numbers the responder maps by default
    typedef enum logic [CSR_ADDR_W-1:0] {
        CSR_XSCRATCH0 = 12'h7C0,
        CSR_XCYCLE    = 12'h7D0
    } csr_num_e;

    // CSR operation encoding
    typedef enum logic [1:0] {
        CSR_OP_READ  = 2'b00,
        CSR_OP_WRITE = 2'b01,
        CSR_OP_SET   = 2'b10,
        CSR_OP_CLEAR = 2'b11
    } csr_op_e;

    // Response payload returned with the rvalid strobe
    typedef struct packed {
        logic                  illegal;
        logic [CSR_DATA_W-1:0] rdata;
    } csr_resp_t;

    // New register value after applying op to old with operand wdata
    function automatic logic [CSR_DATA_W-1:0] csr_apply_op(
        input csr_op_e               op,
        input logic [CSR_DATA_W-1:0] old,
        input logic [CSR_DATA_W-1:0] wdata
    );
        logic [CSR_DATA_W-1:0] res;
        res = old;
        case (op)
            CSR_OP_WRITE: res = wdata;
            CSR_OP_SET:   res = old | wdata;
            CSR_OP_CLEAR: res = old & ~wdata;
            default:      res = old;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/core_ibex_xif_csr_responder.sv
// CSR access responder: scratch CSR bank plus read-only cycle counter,
// one outstanding access, pre-op value returned after a fixed latency.
module core_ibex_xif_csr_responder
    import ibex_xif_pkg::*;
#(
    parameter int unsigned NUM_SCRATCH  = 4,
    parameter logic [11:0] BASE_ADDR    = CSR_XSCRATCH0,
    parameter logic [11:0] CYCLE_ADDR   = CSR_XCYCLE,
    parameter int unsigned RESP_LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        csr_access_i,
    output logic        csr_ready_o,
    input  logic [11:0] csr_addr_i,
    input  logic [1:0]  csr_op_i,
    input  logic [31:0] csr_wdata_i,
    output logic        csr_rvalid_o,
    output logic [31:0] csr_rdata_o,
    output logic        csr_illegal_o
);

    localparam int unsigned LAT_W    = 4;
    localparam int unsigned LAT_LOAD = (RESP_LATENCY > 1) ? RESP_LATENCY - 2 : 0;
    localparam logic [11:0] CYCLE_OFF = CYCLE_ADDR - BASE_ADDR;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_e;

    // Parameter sanity checks at elaboration
    if (NUM_SCRATCH < 1 || NUM_SCRATCH > 16) begin : g_chk_num_scratch
        $error("NUM_SCRATCH must be within 1..16");
    end
    if (RESP_LATENCY < 1 || RESP_LATENCY > 15) begin : g_chk_latency
        $error("RESP_LATENCY must be within 1..15");
    end
    if (CYCLE_OFF < 12'(NUM_SCRATCH)) begin : g_chk_cycle_addr
        $error("CYCLE_ADDR overlaps the scratch range");
    end

    resp_state_e       state_q, state_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [31:0]       scratch_q [NUM_SCRATCH];
    logic [31:0]       cycle_cnt;
    csr_resp_t         pend_q, resp_q, acc_resp;
    logic              ready_q, rvalid_q;

    logic              transfer;
    logic [11:0]       offset;
    logic              scratch_hit, cycle_hit, illegal;
    csr_op_e           op;
    logic [31:0]       scratch_rd;

    assign transfer = csr_access_i & ready_q;
    assign op       = csr_op_e'(csr_op_i);

    // Address decode and pre-op read value of the current request
    always_comb begin
        offset      = csr_addr_i - BASE_ADDR;
        scratch_hit = offset < 12'(NUM_SCRATCH);
        cycle_hit   = csr_addr_i == CYCLE_ADDR;
        illegal     = !(scratch_hit || (cycle_hit && op == CSR_OP_READ));
        scratch_rd  = '0;
        for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
            if (offset == 12'(i)) scratch_rd = scratch_q[i];
        end
        acc_resp.illegal = illegal;
        if (illegal)          acc_resp.rdata = '0;
        else if (scratch_hit) acc_resp.rdata = scratch_rd;
        else                  acc_resp.rdata = cycle_cnt;
    end

    // Next-state logic for the response sequencer
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        case (state_q)
            IDLE: begin
                if (transfer) begin
                    if (RESP_LATENCY > 1) begin
                        state_d = WAIT;
                        lat_d   = LAT_W'(LAT_LOAD);
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (lat_q == '0) state_d = RESP;
                else             lat_d   = lat_q - LAT_W'(1);
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, latency counter and registered handshake outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            lat_q    <= '0;
            ready_q  <= 1'b1;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lat_q    <= lat_d;
            ready_q  <= (state_d == IDLE);
            rvalid_q <= (state_d == RESP);
        end
    end

    // Capture pending response on accept; publish it when entering RESP
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q <= '0;
            resp_q <= '0;
        end else begin
            if (transfer) pend_q <= acc_resp;
            if (state_d == RESP) resp_q <= (state_q == IDLE) ? acc_resp : pend_q;
        end
    end

    // Scratch register update committed on the accept edge
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
                if (transfer && scratch_hit && offset == 12'(i)) begin
                    scratch_q[i] <= csr_apply_op(op, scratch_q[i], csr_wdata_i);
                end
            end
        end
    end

    // Free-running cycle counter, wraps naturally
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cycle_cnt <= '0;
        else       cycle_cnt <= cycle_cnt + 32'd1;
    end

    assign csr_ready_o   = ready_q;
    assign csr_rvalid_o  = rvalid_q;
    assign csr_rdata_o   = resp_q.rdata;
    assign csr_illegal_o = resp_q.illegal;

endmodule

// File: tb/tb_core_ibex_xif_csr_responder.sv
// Directed bench for the CSR responder: latency-1 and latency-3 instances.
module tb_core_ibex_xif_csr_responder;
    import ibex_xif_pkg::*;

    logic        clk, rst;
    logic        acc1, rdy1, rv1, il1;
    logic [11:0] addr1;
    logic [1:0]  op1;
    logic [31:0] wd1, rd1;
    logic        acc3, rdy3, rv3, il3;
    logic [11:0] addr3;
    logic [1:0]  op3;
    logic [31:0] wd3, rd3;

    int vectors     = 0;
    int miscompares = 0;

    core_ibex_xif_csr_responder #(.RESP_LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .csr_access_i(acc1), .csr_ready_o(rdy1),
        .csr_addr_i(addr1), .csr_op_i(op1), .csr_wdata_i(wd1),
        .csr_rvalid_o(rv1), .csr_rdata_o(rd1), .csr_illegal_o(il1)
    );

    core_ibex_xif_csr_responder #(.RESP_LATENCY(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .csr_access_i(acc3), .csr_ready_o(rdy3),
        .csr_addr_i(addr3), .csr_op_i(op3), .csr_wdata_i(wd3),
        .csr_rvalid_o(rv3), .csr_rdata_o(rd3), .csr_illegal_o(il3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One access on the selected instance; waits (bounded) for the response strobe
    task automatic xfer(input bit d3, input logic [11:0] a, input logic [1:0] o,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic il, output int lat);
        bit got;
        got = 1'b0; rd = '0; il = 1'b0; lat = 0;
        @(negedge clk);
        if (d3) begin acc3 = 1'b1; addr3 = a; op3 = o; wd3 = wd; end
        else    begin acc1 = 1'b1; addr1 = a; op1 = o; wd1 = wd; end
        @(posedge clk);
        #1;
        acc1 = 1'b0; addr1 = 'x; op1 = 'x; wd1 = 'x;
        acc3 = 1'b0; addr3 = 'x; op3 = 'x; wd3 = 'x;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            lat = lat + 1;
            if (d3 ? rv3 : rv1) begin
                got = 1'b1;
                rd  = d3 ? rd3 : rd1;
                il  = d3 ? il3 : il1;
            end
        end
        if (!got) check("rvalid_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [31:0] rd, c0, c1, c2;
        logic        il;
        int          lat;
        bit          seen;

        rst = 1'b1;
        acc1 = 1'b0; addr1 = '0; op1 = '0; wd1 = '0;
        acc3 = 1'b0; addr3 = '0; op3 = '0; wd3 = '0;
        repeat (2) @(negedge clk);
        check("rst_ready1",   32'(rdy1), 32'd1);
        check("rst_rvalid1",  32'(rv1),  32'd0);
        check("rst_rdata1",   rd1,       32'd0);
        check("rst_illegal1", 32'(il1),  32'd0);
        check("rst_ready3",   32'(rdy3), 32'd1);
        check("rst_rvalid3",  32'(rv3),  32'd0);
        rst = 1'b0;

        // Write then read back scratch 0
        xfer(0, 12'h7C0, CSR_OP_WRITE, 32'hDEAD_BEEF, rd, il, lat);
        check("t1_wr_rdata", rd, 32'd0);
        check("t1_wr_ill",   32'(il), 32'd0);
        check("t1_wr_lat",   32'(lat), 32'd1);
        xfer(0, 12'h7C0, CSR_OP_READ, 32'h0, rd, il, lat);
        check("t1_rd_rdata", rd, 32'hDEAD_BEEF);
        check("t1_rd_ill",   32'(il), 32'd0);
        repeat (2) @(negedge clk);
        check("hold_rvalid", 32'(rv1), 32'd0);
        check("hold_rdata",  rd1, 32'hDEAD_BEEF);
        check("hold_ready",  32'(rdy1), 32'd1);

        // SET / CLEAR read-modify-write on scratch 1
        xfer(0, 12'h7C1, CSR_OP_WRITE, 32'hF0F0_0000, rd, il, lat);
        check("t2_wr_rdata", rd, 32'd0);
        xfer(0, 12'h7C1, CSR_OP_SET, 32'h0000_00FF, rd, il, lat);
        check("t2_set_rdata", rd, 32'hF0F0_0000);
        xfer(0, 12'h7C1, CSR_OP_CLEAR, 32'hF000_0000, rd, il, lat);
        check("t2_clr_rdata", rd, 32'hF0F0_00FF);
        xfer(0, 12'h7C1, CSR_OP_SET, 32'h0, rd, il, lat);
        check("t2_set0_rdata", rd, 32'h00F0_00FF);
        xfer(0, 12'h7C1, CSR_OP_CLEAR, 32'h0, rd, il, lat);
        check("t2_clr0_rdata", rd, 32'h00F0_00FF);
        xfer(0, 12'h7C1, CSR_OP_READ, 32'h0, rd, il, lat);
        check("t2_rd_rdata", rd, 32'h00F0_00FF);
        check("t2_rd_ill",   32'(il), 32'd0);

        // Decode boundaries and illegal accesses
        xfer(0, 12'h7C3, CSR_OP_READ, 32'h0, rd, il, lat);
        check("t4_last_ill", 32'(il), 32'd0);
        check("t4_last_rd",  rd, 32'd0);
        xfer(0, 12'h7C4, CSR_OP_WRITE, 32'h1234, rd, il, lat);
        check("t4_past_ill", 32'(il), 32'd1);
        xfer(0, 12'h7BF, CSR_OP_READ, 32'h0, rd, il, lat);
        check("t4_below_ill", 32'(il), 32'd1);
        xfer(0, 12'h7FF, CSR_OP_READ, 32'h0, rd, il, lat);
        check("t4_7ff_ill", 32'(il), 32'd1);
        check("t4_7ff_rd",  rd, 32'd0);
        xfer(0, 12'h7C0, CSR_OP_READ, 32'h0, rd, il, lat);
        check("t4_sc0_intact", rd, 32'hDEAD_BEEF);

        // Cycle counter spacing and illegal write to it
        xfer(0, 12'h7D0, CSR_OP_READ, 32'h0, c0, il, lat);
        check("t5_cnt_ill", 32'(il), 32'd0);
        repeat (3) @(negedge clk);
        xfer(0, 12'h7D0, CSR_OP_READ, 32'h0, c1, il, lat);
        check("t5_cnt_diff5", c1 - c0, 32'd5);
        xfer(0, 12'h7D0, CSR_OP_WRITE, 32'h0, rd, il, lat);
        check("t4_cntwr_ill", 32'(il), 32'd1);
        check("t4_cntwr_rd",  rd, 32'd0);
        xfer(0, 12'h7D0, CSR_OP_READ, 32'h0, c2, il, lat);
        check("t4_cnt_diff4", c2 - c1, 32'd4);

        // Counter wrap
        force dut1.cycle_cnt = 32'hFFFF_FFFE;
        release dut1.cycle_cnt;
        xfer(0, 12'h7D0, CSR_OP_READ, 32'h0, rd, il, lat);
        check("t5_wrap_pre", rd, 32'hFFFF_FFFF);
        xfer(0, 12'h7D0, CSR_OP_READ, 32'h0, rd, il, lat);
        check("t5_wrap_post", rd, 32'h0000_0001);

        // Latency-3 cycle-by-cycle timing
        @(negedge clk);
        check("t3_ready_pre", 32'(rdy3), 32'd1);
        acc3 = 1'b1; addr3 = 12'h7C2; op3 = CSR_OP_WRITE; wd3 = 32'h1234_5678;
        @(posedge clk);
        #1;
        acc3 = 1'b0; addr3 = 'x; op3 = 'x; wd3 = 'x;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check($sformatf("t3_rvalid_c%0d", i), 32'(rv3), 32'(i == 3));
            check($sformatf("t3_ready_c%0d", i),  32'(rdy3), 32'(i >= 4));
            if (i == 3) check("t3_rdata", rd3, 32'd0);
        end
        xfer(1, 12'h7C2, CSR_OP_READ, 32'h0, rd, il, lat);
        check("t3_rd_rdata", rd, 32'h1234_5678);
        check("t3_rd_lat",   32'(lat), 32'd3);

        // Reset during WAIT discards the pending response and clears regs
        @(negedge clk);
        acc3 = 1'b1; addr3 = 12'h7C1; op3 = CSR_OP_WRITE; wd3 = 32'h55;
        @(posedge clk);
        #1;
        acc3 = 1'b0; addr3 = 'x; op3 = 'x; wd3 = 'x;
        @(negedge clk);
        check("t6_in_wait", 32'(rdy3), 32'd0);
        rst = 1'b1;
        #1;
        check("t6_rst_ready", 32'(rdy3), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rv3) seen = 1'b1;
        end
        check("t6_no_rvalid", 32'(seen), 32'd0);
        check("t6_ready",     32'(rdy3), 32'd1);
        xfer(1, 12'h7C0, CSR_OP_READ, 32'h0, rd, il, lat);
        check("t6_rd_7c0", rd, 32'd0);
        xfer(1, 12'h7C2, CSR_OP_READ, 32'h0, rd, il, lat);
        check("t6_rd_7c2", rd, 32'd0);
        xfer(0, 12'h7C0, CSR_OP_READ, 32'h0, rd, il, lat);
        check("t6_dut1_7c0", rd, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
